systolic_mac_cell: RTL and testbench
====================================

Name: systolic_mac_cell

Overview:
- Single processing cell of a 2-D output-stationary/diagonal-sum systolic array for small unsigned matrix multiply (3x3 on a 5x5 cell grid).
- Operand A flows left-to-right and operand B flows top-to-bottom, each with one register stage per cell.
- In MAC mode, the cell adds A*B to an incoming partial sum and passes the result diagonally (down-right).
- In delay mode, the cell only retimes A and B and is used as padding/skew cells at array edges.

Parameters:
- N, 5, operand width in bits for A and B.
- SUM_W, 2*N+4, partial-sum width (14 at N=5); headroom for accumulating up to 16 products.
- DELAY_ONLY, 0, 0 = MAC cell; 1 = delay cell (no arithmetic, c_out tied to registered zero).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a_in  input  N  operand A from west neighbour, unsigned.
- b_in  input  N  operand B from north neighbour, unsigned.
- c_in  input  SUM_W  partial sum from north-west neighbour, unsigned; array edges drive 0.
- a_out  output  N  registered A to east neighbour.
- b_out  output  N  registered B to south neighbour.
- c_out  output  SUM_W  registered partial sum to south-east neighbour.

Behaviour:
- All outputs are registers updated only on the rising edge of clk; there is no combinational path from inputs to outputs.
- Reset:
  - rst=1 at a clock edge: a_out, b_out, c_out <= 0.
  - Reset has priority over the data update in the same cycle.
  - Reset mid-stream discards all in-flight data; the first post-reset edge with rst=0 captures the inputs present at that edge.
- MAC mode (DELAY_ONLY=0), each edge with rst=0:
  - a_out <= a_in; b_out <= b_in.
  - c_out <= (c_in + a_in*b_in) mod 2^SUM_W.
  - Product is unsigned, full 2N bits, zero-extended to SUM_W before the add; no saturation, and the sum wraps silently.
- Delay mode (DELAY_ONLY=1), each edge with rst=0:
  - a_out <= a_in; b_out <= b_in; c_out <= 0.
  - c_in is ignored.
  - Implementation must not instantiate a multiplier in this mode (generate-guarded).
- Latency is exactly one cycle for all three paths in both modes; throughput is one operand pair per cycle.
- No enable and no handshake: the cell advances every cycle, and zero inputs act as bubbles (0*x adds nothing).
- Initial (pre-reset) register values are undefined for synthesis; simulation may initialise to 0.
- Array-level contract, informational only (the array itself lives elsewhere):
  - A is skewed by row and B by column via delay cells.
  - Result C[i][j] appears on c_out of the last cell on its diagonal, 2N-1 cycles or more after the first operand enters.

Test Plan:
- Reset: drive random inputs with rst=1 for 2 edges -> a_out=0, b_out=0, c_out=0. Release rst with a_in=3, b_in=4, c_in=10 -> after 1 edge c_out=22, a_out=3, b_out=4.
- Overflow wrap (N=5, SUM_W=14): a_in=31, b_in=31, c_in=16383 -> c_out=960; a_in=31, b_in=31, c_in=0 -> c_out=961.
- Back-to-back streaming: pairs (1,2,0), (5,6,7), (0,9,100) on consecutive edges -> c_out sequence 2, 37, 100 on consecutive edges, each exactly one cycle after its input.
- Delay mode (DELAY_ONLY=1): a_in=7, b_in=9, c_in=100 -> a_out=7, b_out=9, c_out=0; sweep all a/b values and check c_out stays 0.
- Chain of 3 MAC cells with c_out feeding c_in, a_in per stage 1,2,3, b_in per stage 4,5,6, each aligned to its arrival cycle -> final c_out=32, appearing 3 cycles after the first input.
- Mid-stream reset: assert rst for one edge while a nonzero stream runs -> that edge's outputs are 0, and the next edge reflects only the post-reset inputs (no stale sum).

Source files
------------

// File: rtl/systolic_mac_cell_if.sv
// Operand/partial-sum bundle for one systolic MAC cell.
// The cell uses the slave modport; whatever feeds it uses master.
`timescale 1ns/1ps
interface systolic_mac_cell_if #(
  parameter int N     = 5,
  parameter int SUM_W = 2*N+4
);
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic [SUM_W-1:0] c_in;
  logic [N-1:0]     a_out;
  logic [N-1:0]     b_out;
  logic [SUM_W-1:0] c_out;

  modport master (
    output a_in, b_in, c_in,
    input  a_out, b_out, c_out
  );

  modport slave (
    input  a_in, b_in, c_in,
    output a_out, b_out, c_out
  );
endinterface

// File: rtl/systolic_mac_cell.sv
// One cell of an output-stationary / diagonal-sum systolic array.
// A moves east, B moves south, the partial sum moves south-east; every
// path is a single register stage. DELAY_ONLY cells only retime A and B.
`timescale 1ns/1ps
module systolic_mac_cell #(
  parameter int N          = 5,
  parameter int SUM_W      = 2*N+4,
  parameter bit DELAY_ONLY = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_mac_cell_if.slave       bus
);

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [SUM_W-1:0] c_q;
  logic [SUM_W-1:0] c_d;

  generate
    if (DELAY_ONLY == 1'b0) begin : gen_mac
      logic [2*N-1:0] prod;

      // Full-width unsigned product, zero-extended and added with silent wrap.
      always_comb begin
        prod = bus.a_in * bus.b_in;
        c_d  = bus.c_in + SUM_W'(prod);
      end
    end else begin : gen_delay
      // Padding cell: no arithmetic, partial sum is always zero.
      always_comb begin
        c_d = '0;
      end
    end
  endgenerate

  // Pipeline registers; reset wins over the data update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= bus.a_in;
      b_q <= bus.b_in;
      c_q <= c_d;
    end
  end

  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.c_out = c_q;

endmodule

// File: tb/tb_systolic_mac_cell.sv
// Self-checking bench for systolic_mac_cell: a MAC cell, a delay cell and
// a three-cell MAC chain, with expected outputs queued as stimulus is driven.
`timescale 1ns/1ps
module tb_systolic_mac_cell;

  localparam int N     = 5;
  localparam int SUM_W = 2*N+4;

  typedef struct {
    int a;
    int b;
    int c;
  } exp_t;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  exp_t q_mac[$];
  exp_t q_dly[$];
  int   q_chain[$];

  systolic_mac_cell_if #(.N(N), .SUM_W(SUM_W)) mac_if ();
  systolic_mac_cell_if #(.N(N), .SUM_W(SUM_W)) dly_if ();
  systolic_mac_cell_if #(.N(N), .SUM_W(SUM_W)) ch0_if ();
  systolic_mac_cell_if #(.N(N), .SUM_W(SUM_W)) ch1_if ();
  systolic_mac_cell_if #(.N(N), .SUM_W(SUM_W)) ch2_if ();

  systolic_mac_cell #(.N(N), .SUM_W(SUM_W), .DELAY_ONLY(1'b0)) u_mac (
    .clk(clk), .rst(rst), .bus(mac_if.slave));
  systolic_mac_cell #(.N(N), .SUM_W(SUM_W), .DELAY_ONLY(1'b1)) u_dly (
    .clk(clk), .rst(rst), .bus(dly_if.slave));
  systolic_mac_cell #(.N(N), .SUM_W(SUM_W), .DELAY_ONLY(1'b0)) u_ch0 (
    .clk(clk), .rst(rst), .bus(ch0_if.slave));
  systolic_mac_cell #(.N(N), .SUM_W(SUM_W), .DELAY_ONLY(1'b0)) u_ch1 (
    .clk(clk), .rst(rst), .bus(ch1_if.slave));
  systolic_mac_cell #(.N(N), .SUM_W(SUM_W), .DELAY_ONLY(1'b0)) u_ch2 (
    .clk(clk), .rst(rst), .bus(ch2_if.slave));

  // Partial sum flows down the chain.
  assign ch1_if.c_in = ch0_if.c_out;
  assign ch2_if.c_in = ch1_if.c_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned product plus incoming sum, modulo 2^SUM_W.
  function automatic int mac_model(input int a, input int b, input int c);
    longint full;
    full = longint'(c) + longint'(a) * longint'(b);
    return int'(full % (longint'(1) << SUM_W));
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the MAC cell: drive, queue the expected result, compare.
  task automatic mac_step(input string tag, input bit rst_v,
                          input int a, input int b, input int c);
    exp_t e;
    exp_t got;
    rst = rst_v;
    mac_if.a_in = N'(a);
    mac_if.b_in = N'(b);
    mac_if.c_in = SUM_W'(c);
    if (rst_v) begin
      e.a = 0; e.b = 0; e.c = 0;
    end else begin
      e.a = a; e.b = b; e.c = mac_model(a, b, c);
    end
    q_mac.push_back(e);
    tick();
    got = q_mac.pop_front();
    check_val({tag, ".a"}, int'(mac_if.a_out), got.a);
    check_val({tag, ".b"}, int'(mac_if.b_out), got.b);
    check_val({tag, ".c"}, int'(mac_if.c_out), got.c);
  endtask

  // One cycle on the delay cell (reset held low).
  task automatic dly_step(input string tag, input int a, input int b, input int c);
    exp_t got;
    exp_t e;
    rst = 1'b0;
    dly_if.a_in = N'(a);
    dly_if.b_in = N'(b);
    dly_if.c_in = SUM_W'(c);
    e.a = a; e.b = b; e.c = 0;
    q_dly.push_back(e);
    tick();
    got = q_dly.pop_front();
    check_val({tag, ".a"}, int'(dly_if.a_out), got.a);
    check_val({tag, ".b"}, int'(dly_if.b_out), got.b);
    check_val({tag, ".c"}, int'(dly_if.c_out), got.c);
  endtask

  task automatic zero_chain();
    ch0_if.a_in = '0; ch0_if.b_in = '0; ch0_if.c_in = '0;
    ch1_if.a_in = '0; ch1_if.b_in = '0;
    ch2_if.a_in = '0; ch2_if.b_in = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    mac_if.a_in = '0; mac_if.b_in = '0; mac_if.c_in = '0;
    dly_if.a_in = '0; dly_if.b_in = '0; dly_if.c_in = '0;
    zero_chain();

    // Reset with random inputs for two edges.
    for (int i = 0; i < 2; i++) begin
      dly_if.a_in = N'($urandom);
      dly_if.b_in = N'($urandom);
      dly_if.c_in = SUM_W'($urandom);
      mac_step("reset", 1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 16383)));
      check_val("reset.dly_a", int'(dly_if.a_out), 0);
      check_val("reset.dly_c", int'(dly_if.c_out), 0);
      check_val("reset.chain_c", int'(ch2_if.c_out), 0);
    end

    // First capture after release.
    mac_step("release", 1'b0, 3, 4, 10);

    // Overflow wrap.
    mac_step("wrap_full", 1'b0, 31, 31, 16383);
    mac_step("wrap_zero", 1'b0, 31, 31, 0);

    // Back-to-back streaming.
    mac_step("stream0", 1'b0, 1, 2, 0);
    mac_step("stream1", 1'b0, 5, 6, 7);
    mac_step("stream2", 1'b0, 0, 9, 100);

    // Random streaming.
    for (int i = 0; i < 20; i++) begin
      mac_step("rand", 1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 16383)));
    end

    // Mid-stream reset: one reset edge, then only post-reset data.
    mac_step("mid_pre", 1'b0, 3, 5, 7);
    mac_step("mid_rst", 1'b1, 9, 9, 9);
    mac_step("mid_post", 1'b0, 2, 2, 0);

    // Delay cell.
    dly_step("dly_basic", 7, 9, 100);
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        dly_step("dly_sweep", a, b, int'($urandom_range(0, 16383)));
      end
    end

    // Chain of three MAC cells, operands aligned to the sum's arrival.
    zero_chain();
    tick();
    tick();
    q_chain.push_back(0);
    q_chain.push_back(0);
    q_chain.push_back(mac_model(3, 6, mac_model(2, 5, mac_model(1, 4, 0))));
    ch0_if.a_in = 5'd1; ch0_if.b_in = 5'd4;
    tick();
    check_val("chain.c0", int'(ch0_if.c_out), mac_model(1, 4, 0));
    check_val("chain.t1", int'(ch2_if.c_out), q_chain.pop_front());
    ch0_if.a_in = '0; ch0_if.b_in = '0;
    ch1_if.a_in = 5'd2; ch1_if.b_in = 5'd5;
    tick();
    check_val("chain.c1", int'(ch1_if.c_out), mac_model(2, 5, 4));
    check_val("chain.t2", int'(ch2_if.c_out), q_chain.pop_front());
    ch1_if.a_in = '0; ch1_if.b_in = '0;
    ch2_if.a_in = 5'd3; ch2_if.b_in = 5'd6;
    tick();
    check_val("chain.t3", int'(ch2_if.c_out), q_chain.pop_front());
    check_val("chain.final32", int'(ch2_if.c_out), 32);
    zero_chain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
